// File: rtl/multi_channel_send_scheduler_if.sv
// Time-of-day inputs, per-channel request/ack and sticky status flags for the send scheduler.
// OVERRUN_CNT_EN adds the per-channel overrun event counter bus.
interface multi_channel_send_scheduler_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CW     = 6
);
  logic                 enable;
  logic [5:0]           minutes;
  logic [5:0]           seconds;
  logic [NUM_CH*CW-1:0] interval;
  logic [NUM_CH-1:0]    send_ack;
  logic                 clr_flags;
  logic [NUM_CH-1:0]    send_data;
  logic [NUM_CH-1:0]    overrun;
  logic [NUM_CH-1:0]    timeout;

`ifdef OVERRUN_CNT_EN
  logic [NUM_CH*8-1:0]  overrun_cnt;

  modport master (
    output enable, minutes, seconds, interval, send_ack, clr_flags,
    input  send_data, overrun, timeout, overrun_cnt
  );

  modport slave (
    input  enable, minutes, seconds, interval, send_ack, clr_flags,
    output send_data, overrun, timeout, overrun_cnt
  );
`else
  modport master (
    output enable, minutes, seconds, interval, send_ack, clr_flags,
    input  send_data, overrun, timeout
  );

  modport slave (
    input  enable, minutes, seconds, interval, send_ack, clr_flags,
    output send_data, overrun, timeout
  );
`endif

endinterface

// File: rtl/multi_channel_send_scheduler.sv
// Raises an active-low send request per channel every interval minutes, held until ack or seconds timeout.
// Define OVERRUN_CNT_EN to add per-channel saturating overrun event counters.
module multi_channel_send_scheduler #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned CW       = 6,
  parameter int unsigned HOLD_SEC = 1   // 0 = hold until ack only, max 63
) (
  input logic clk,
  input logic rst,
  multi_channel_send_scheduler_if.slave bus
);

  typedef enum logic {
    IDLE,
    REQ
  } ch_state_t;

  localparam logic [5:0] HOLD_LAST = (HOLD_SEC == 0) ? 6'd0 : 6'(HOLD_SEC - 1);

  logic              init;
  logic [5:0]        min_q;
  logic [5:0]        sec_q;
  logic              min_tick;
  logic              sec_tick;

  logic [CW-1:0]     iv      [NUM_CH];
  logic [CW-1:0]     cnt_q   [NUM_CH];
  logic [CW-1:0]     cnt_d   [NUM_CH];
  logic [5:0]        hold_q  [NUM_CH];
  logic [5:0]        hold_d  [NUM_CH];
  ch_state_t         state_q [NUM_CH];
  ch_state_t         state_d [NUM_CH];

  logic [NUM_CH-1:0] fire;
  logic [NUM_CH-1:0] ovr_set;
  logic [NUM_CH-1:0] to_set;
  logic [NUM_CH-1:0] send_q;
  logic [NUM_CH-1:0] overrun_q;
  logic [NUM_CH-1:0] timeout_q;

  // init masks the first post-reset sample so a stale min_q/sec_q cannot tick
  assign min_tick = init & (bus.minutes != min_q);
  assign sec_tick = init & (bus.seconds != sec_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      init  <= 1'b0;
      min_q <= '0;
      sec_q <= '0;
    end else begin
      init  <= 1'b1;
      min_q <= bus.minutes;
      sec_q <= bus.seconds;
    end
  end

  always_comb begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      iv[c] = bus.interval[c*CW +: CW];
    end
  end

  // >= rather than == so a shortened interval fires on the very next tick
  always_comb begin
    fire = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      cnt_d[c] = cnt_q[c];
      if (iv[c] == '0) begin
        cnt_d[c] = '0;
      end else if (min_tick && bus.enable) begin
        if (cnt_q[c] >= iv[c] - CW'(1)) begin
          cnt_d[c] = '0;
          fire[c]  = 1'b1;
        end else begin
          cnt_d[c] = cnt_q[c] + CW'(1);
        end
      end
    end
  end

  // A fire pre-empts ack and any same-cycle seconds tick on that channel
  always_comb begin
    ovr_set = '0;
    to_set  = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      state_d[c] = state_q[c];
      hold_d[c]  = hold_q[c];
      case (state_q[c])
        IDLE: begin
          if (fire[c]) begin
            state_d[c] = REQ;
            hold_d[c]  = '0;
          end
        end
        REQ: begin
          if (fire[c]) begin
            hold_d[c]  = '0;
            ovr_set[c] = ~bus.send_ack[c];
          end else if (bus.send_ack[c]) begin
            state_d[c] = IDLE;
          end else if (sec_tick && (HOLD_SEC != 0)) begin
            if (hold_q[c] == HOLD_LAST) begin
              state_d[c] = IDLE;
              to_set[c]  = 1'b1;
            end else begin
              hold_d[c] = hold_q[c] + 6'd1;
            end
          end
        end
        default: begin
          state_d[c] = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        state_q[c] <= IDLE;
        cnt_q[c]   <= '0;
        hold_q[c]  <= '0;
      end
      send_q    <= '1;
      overrun_q <= '0;
      timeout_q <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        state_q[c] <= state_d[c];
        cnt_q[c]   <= cnt_d[c];
        hold_q[c]  <= hold_d[c];
        send_q[c]  <= (state_d[c] != REQ);
      end
      overrun_q <= ovr_set | (overrun_q & ~{NUM_CH{bus.clr_flags}});
      timeout_q <= to_set  | (timeout_q & ~{NUM_CH{bus.clr_flags}});
    end
  end

  assign bus.send_data = send_q;
  assign bus.overrun   = overrun_q;
  assign bus.timeout   = timeout_q;

`ifdef OVERRUN_CNT_EN
  logic [7:0]          ocnt_q [NUM_CH];
  logic [NUM_CH*8-1:0] ocnt_flat;

  always_ff @(posedge clk) begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (rst) begin
        ocnt_q[c] <= '0;
      end else if (ovr_set[c]) begin
        if (bus.clr_flags) begin
          ocnt_q[c] <= 8'd1;
        end else if (ocnt_q[c] != '1) begin
          ocnt_q[c] <= ocnt_q[c] + 8'd1;
        end
      end else if (bus.clr_flags) begin
        ocnt_q[c] <= '0;
      end
    end
  end

  always_comb begin
    ocnt_flat = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      ocnt_flat[c*8 +: 8] = ocnt_q[c];
    end
  end

  assign bus.overrun_cnt = ocnt_flat;
`endif

endmodule

// File: tb/tb_multi_channel_send_scheduler.sv
// Directed bench for multi_channel_send_scheduler: HOLD_SEC=1 instance plus a HOLD_SEC=0 twin on shared inputs.
module tb_multi_channel_send_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  int unsigned checks   = 0;
  int unsigned failures = 0;

  always #5 clk = ~clk;

  multi_channel_send_scheduler_if #(.NUM_CH(4), .CW(6)) bus  ();
  multi_channel_send_scheduler_if #(.NUM_CH(4), .CW(6)) bus0 ();

  assign bus0.enable    = bus.enable;
  assign bus0.minutes   = bus.minutes;
  assign bus0.seconds   = bus.seconds;
  assign bus0.interval  = bus.interval;
  assign bus0.send_ack  = bus.send_ack;
  assign bus0.clr_flags = bus.clr_flags;

  multi_channel_send_scheduler #(.NUM_CH(4), .CW(6), .HOLD_SEC(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  multi_channel_send_scheduler #(.NUM_CH(4), .CW(6), .HOLD_SEC(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick_min();
    bus.minutes = bus.minutes + 6'd1;
    @(negedge clk);
  endtask

  task automatic tick_sec();
    bus.seconds = bus.seconds + 6'd1;
    @(negedge clk);
  endtask

  task automatic pulse_ack(input logic [3:0] mask);
    bus.send_ack = mask;
    @(negedge clk);
    bus.send_ack = '0;
  endtask

  task automatic pulse_clr();
    bus.clr_flags = 1'b1;
    @(negedge clk);
    bus.clr_flags = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    bus.enable    = 1'b1;
    bus.minutes   = '0;
    bus.seconds   = '0;
    bus.interval  = '0;
    bus.send_ack  = '0;
    bus.clr_flags = 1'b0;
    idle(3);
    check("rst_send", bus.send_data, 4'hF);
    check("rst_ovr", bus.overrun, 4'h0);
    check("rst_to", bus.timeout, 4'h0);
    check("rst_send_h0", bus0.send_data, 4'hF);
    rst = 1'b0;
    idle(2);

    // Channel 0 every 4 minutes, dropped by the first seconds change
    bus.interval[5:0] = 6'd4;
    for (int k = 0; k < 3; k++) begin
      tick_min();
      idle(19);
    end
    check("t1_pre_fire", bus.send_data[0], 1'b1);
    tick_min();
    check("t1_fire", bus.send_data, 4'hE);
    idle(19);
    check("t1_hold", bus.send_data[0], 1'b0);
    tick_sec();
    check("t1_to_send", bus.send_data[0], 1'b1);
    check("t1_to_flag", bus.timeout, 4'h1);
    check("t1_h0_hold", bus0.send_data[0], 1'b0);
    check("t1_h0_to", bus0.timeout, 4'h0);
    tick_min();
    idle(19);
    pulse_clr();
    check("t1_clr", bus.timeout, 4'h0);

    // Ack path: three more ticks complete the interval, ack 3 cycles later
    tick_min();
    idle(19);
    tick_min();
    idle(19);
    tick_min();
    check("t2_fire", bus.send_data[0], 1'b0);
    check("t2_h0_ovr", bus0.overrun, 4'h1);
    idle(2);
    pulse_ack(4'h1);
    check("t2_ack_send", bus.send_data, 4'hF);
    check("t2_ack_to", bus.timeout, 4'h0);
    check("t2_ack_h0", bus0.send_data, 4'hF);
    for (int k = 0; k < 3; k++) begin
      tick_min();
      idle(19);
    end
    check("t2_no_early", bus.send_data[0], 1'b1);
    tick_min();
    check("t2_refire", bus.send_data[0], 1'b0);
    pulse_ack(4'h1);
    check("t2_ack2", bus.send_data, 4'hF);
    check("t2_ovr_none", bus.overrun, 4'h0);

    // Channel 1 every minute: overruns, counters, flag clear priority
    bus.interval       = '0;
    bus.interval[11:6] = 6'd1;
    tick_min();
    check("t3_fire_h1", bus.send_data, 4'hD);
    check("t3_fire_h0", bus0.send_data, 4'hD);
    tick_sec();
    check("t3_h1_to", bus.timeout, 4'h2);
    check("t3_h0_hold", bus0.send_data, 4'hD);
    idle(18);
    tick_min();
    check("t3_h0_ovr", bus0.overrun, 4'h3);
    check("t3_h0_send", bus0.send_data, 4'hD);
    check("t3_h1_ovr", bus.overrun, 4'h0);
    check("t3_h1_send", bus.send_data, 4'hD);
`ifdef OVERRUN_CNT_EN
    check("t3_h0_ocnt2", bus0.overrun_cnt[15:8], 8'd1);
`endif
    idle(19);
    tick_min();
    check("t3_h1_ovr2", bus.overrun, 4'h2);
    check("t3_h0_to", bus0.timeout, 4'h0);
`ifdef OVERRUN_CNT_EN
    check("t3_h0_ocnt3", bus0.overrun_cnt[15:8], 8'd2);
    check("t3_h1_ocnt", bus.overrun_cnt[15:8], 8'd1);
`endif
    idle(19);
    bus.clr_flags = 1'b1;
    tick_min();
    bus.clr_flags = 1'b0;
    check("t3_setwins_h1", bus.overrun, 4'h2);
    check("t3_clr_to", bus.timeout, 4'h0);
    check("t3_setwins_h0", bus0.overrun, 4'h2);
`ifdef OVERRUN_CNT_EN
    check("t3_ocnt_clrinc_h0", bus0.overrun_cnt[15:8], 8'd1);
    check("t3_ocnt_clrinc_h1", bus.overrun_cnt[15:8], 8'd1);
`endif
    pulse_clr();
    check("t3_clr_h1", bus.overrun, 4'h0);
    check("t3_clr_h0", bus0.overrun, 4'h0);
`ifdef OVERRUN_CNT_EN
    check("t3_ocnt_clr", bus0.overrun_cnt, 32'h0);
`endif
    pulse_ack(4'hF);
    check("t3_ack_h1", bus.send_data, 4'hF);
    check("t3_ack_h0", bus0.send_data, 4'hF);

    // Channel 2 disabled by interval 0, channel 3 frozen by enable=0
    bus.interval        = '0;
    bus.interval[23:18] = 6'd2;
    bus.enable          = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick_min();
      check("t4_frozen", bus.send_data, 4'hF);
      idle(19);
    end
    bus.enable = 1'b1;
    tick_min();
    check("t4_first", bus.send_data, 4'hF);
    idle(19);
    tick_min();
    check("t4_fire", bus.send_data, 4'h7);
    check("t4_fire_h0", bus0.send_data, 4'h7);
    pulse_ack(4'hF);

    // Reset while requests and flags are pending
    bus.interval[5:0] = 6'd4;
    for (int k = 0; k < 4; k++) begin
      tick_min();
      idle(19);
    end
    check("t5_pre_send", bus.send_data, 4'h6);
    check("t5_pre_ovr", bus.overrun, 4'h8);
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_send", bus.send_data, 4'hF);
    check("t5_rst_ovr", bus.overrun, 4'h0);
    check("t5_rst_to", bus.timeout, 4'h0);
    check("t5_rst_h0", bus0.send_data, 4'hF);
    rst = 1'b0;
    tick_min();
    idle(19);
    for (int k = 0; k < 3; k++) begin
      tick_min();
      idle(19);
    end
    check("t5_no_early", bus.send_data[0], 1'b1);
    tick_min();
    check("t5_fire", bus.send_data, 4'h6);

    // Minute and second change together at channel 0's fire point
    for (int k = 0; k < 3; k++) begin
      idle(19);
      tick_min();
    end
    idle(19);
    bus.seconds = bus.seconds + 6'd1;
    tick_min();
    check("t6_rearm_send", bus.send_data, 4'h6);
    check("t6_no_to", bus.timeout, 4'h0);
    check("t6_ovr", bus.overrun, 4'h9);
    idle(19);
    bus.clr_flags = 1'b1;
    tick_sec();
    bus.clr_flags = 1'b0;
    check("t6_to_send", bus.send_data, 4'hF);
    check("t6_to_setwins", bus.timeout, 4'h9);
    check("t6_ovr_clr", bus.overrun, 4'h0);
    check("t6_h0_hold", bus0.send_data, 4'h6);
    check("t6_h0_to", bus0.timeout, 4'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
